// File: rtl/random_word_ctrl.sv
// random_word_ctrl: sequencing controller for the 8-bit LFSR random engine.
// Accepts tap/seed configuration and word requests over val/rdy, runs the
// LFSR for exactly N cycles while shifting its serial output into a
// right-aligned word, and returns that word over a val/rdy response port.
//
// Handshake rule for every val/rdy pair: a transfer happens on a rising edge
// where both val and rdy are high; val never waits on rdy, and the side
// raising val holds its payload stable until that transfer edge.
//
// Optional build macro RANDOM_WORD_CTRL_FREERUN_EN: when defined the LFSR is
// also enabled in IDLE and RESP (free-running); RESEED always disables it and
// bits are only ever sampled in GEN.
`timescale 1ns/1ps
module random_word_ctrl #(
  parameter int         WORD_W   = 16,
  parameter int         NB_W     = 5,
  parameter logic [7:0] RST_TAP  = 8'hB8,
  parameter logic [7:0] RST_SEED = 8'h01
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_val,
  output logic              cfg_rdy,
  input  logic [7:0]        cfg_tap,
  input  logic [7:0]        cfg_seed,
  input  logic              req_val,
  output logic              req_rdy,
  input  logic [NB_W-1:0]   req_nbits,
  output logic              resp_val,
  input  logic              resp_rdy,
  output logic [WORD_W-1:0] resp_word,
  output logic [7:0]        tap,
  output logic [7:0]        seed,
  output logic              lfsr_reseed,
  output logic              lfsr_en,
  input  logic              lfsr_out,
  output logic [1:0]        dbg_state_o
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RESEED = 2'd1,
    S_GEN    = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  localparam logic [NB_W-1:0] WORD_CNT = NB_W'(WORD_W);
  localparam logic [NB_W-1:0] CNT_ONE  = NB_W'(1);

  state_t              state_q, state_d;
  logic [7:0]          tap_q, seed_q;
  logic [WORD_W-1:0]   word_q;
  logic [NB_W-1:0]     cnt_q;
  logic [NB_W-1:0]     eff_cnt;
  logic                cfg_rdy_q, resp_val_q, reseed_q, lfsr_en_q;
  logic                lfsr_en_d;

  // Zero or oversized requests are clamped to the full word width.
  always_comb begin
    eff_cnt = req_nbits;
    if (req_nbits == '0 || req_nbits > WORD_CNT) eff_cnt = WORD_CNT;
  end

  // Next-state logic; cfg wins over req when both are valid in IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (cfg_val)      state_d = S_RESEED;
        else if (req_val) state_d = S_GEN;
      end
      S_RESEED: state_d = S_IDLE;
      S_GEN:    if (cnt_q == CNT_ONE) state_d = S_RESP;
      S_RESP:   if (resp_rdy) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // LFSR enable for the upcoming state, chosen by the free-run option.
  always_comb begin
`ifdef RANDOM_WORD_CTRL_FREERUN_EN
    lfsr_en_d = (state_d != S_RESEED);
`else
    lfsr_en_d = (state_d == S_GEN);
`endif
  end

  // FSM state, datapath registers and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      tap_q      <= RST_TAP;
      seed_q     <= RST_SEED;
      word_q     <= '0;
      cnt_q      <= '0;
      cfg_rdy_q  <= 1'b0;
      resp_val_q <= 1'b0;
      reseed_q   <= 1'b0;
      lfsr_en_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cfg_rdy_q  <= (state_d == S_IDLE);
      resp_val_q <= (state_d == S_RESP);
      reseed_q   <= (state_d == S_RESEED);
      lfsr_en_q  <= lfsr_en_d;
      case (state_q)
        S_IDLE: begin
          if (cfg_val) begin
            tap_q  <= cfg_tap;
            seed_q <= cfg_seed;
          end else if (req_val) begin
            cnt_q  <= eff_cnt;
            word_q <= '0;
          end
        end
        S_GEN: begin
          // The current LFSR output is sampled before the advance it enables.
          word_q <= {word_q[WORD_W-2:0], lfsr_out};
          cnt_q  <= cnt_q - CNT_ONE;
        end
        default: ;
      endcase
    end
  end

  assign cfg_rdy     = cfg_rdy_q;
  assign req_rdy     = cfg_rdy_q & ~cfg_val;
  assign resp_val    = resp_val_q;
  assign resp_word   = word_q;
  assign tap         = tap_q;
  assign seed        = seed_q;
  assign lfsr_reseed = reseed_q;
  assign lfsr_en     = lfsr_en_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_random_word_ctrl.sv
// Directed bench for random_word_ctrl: reset defaults, basic word capture,
// count clamping, response backpressure, cfg-over-req priority with reseed,
// and abort by mid-operation reset.
`timescale 1ns/1ps
module tb_random_word_ctrl;

  localparam int WORD_W = 16;
  localparam int NB_W   = 5;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_RESEED = 2'd1;
  localparam logic [1:0] ST_GEN    = 2'd2;
  localparam logic [1:0] ST_RESP   = 2'd3;

`ifdef RANDOM_WORD_CTRL_FREERUN_EN
  localparam logic EXP_EN_RESP = 1'b1;
`else
  localparam logic EXP_EN_RESP = 1'b0;
`endif

  logic              clk;
  logic              rst;
  logic              cfg_val;
  logic              cfg_rdy;
  logic [7:0]        cfg_tap;
  logic [7:0]        cfg_seed;
  logic              req_val;
  logic              req_rdy;
  logic [NB_W-1:0]   req_nbits;
  logic              resp_val;
  logic              resp_rdy;
  logic [WORD_W-1:0] resp_word;
  logic [7:0]        tap;
  logic [7:0]        seed;
  logic              lfsr_reseed;
  logic              lfsr_en;
  logic              lfsr_out;
  logic [1:0]        dbg_state;

  int total = 0;
  int bad   = 0;

  random_word_ctrl #(
    .WORD_W(WORD_W), .NB_W(NB_W), .RST_TAP(8'hB8), .RST_SEED(8'h01)
  ) dut (
    .clk(clk), .rst(rst),
    .cfg_val(cfg_val), .cfg_rdy(cfg_rdy), .cfg_tap(cfg_tap), .cfg_seed(cfg_seed),
    .req_val(req_val), .req_rdy(req_rdy), .req_nbits(req_nbits),
    .resp_val(resp_val), .resp_rdy(resp_rdy), .resp_word(resp_word),
    .tap(tap), .seed(seed), .lfsr_reseed(lfsr_reseed), .lfsr_en(lfsr_en),
    .lfsr_out(lfsr_out), .dbg_state_o(dbg_state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver: issue one request and feed pat[i] as the i-th sampled bit.
  // Returns at a negedge with the response pending (or budget expired).
  task automatic run_word(input logic [NB_W-1:0] nb, input logic [31:0] pat,
                          output int en_cnt, output logic got);
    en_cnt = 0;
    got    = 1'b0;
    @(negedge clk);
    req_val   = 1'b1;
    req_nbits = nb;
    @(negedge clk);
    req_val = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (resp_val) begin
        got = 1'b1;
        break;
      end
      if (lfsr_en) begin
        lfsr_out = pat[en_cnt];
        en_cnt++;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    total++; if (tap !== 8'hB8) begin bad++; $display("FAIL reset_tap got=%h exp=b8", tap); end
    total++; if (seed !== 8'h01) begin bad++; $display("FAIL reset_seed got=%h exp=01", seed); end
    total++; if (resp_val !== 1'b0) begin bad++; $display("FAIL reset_resp_val got=%b exp=0", resp_val); end
    total++; if (lfsr_en !== 1'b0 && EXP_EN_RESP == 1'b0) begin bad++; $display("FAIL reset_lfsr_en got=%b exp=0", lfsr_en); end
    total++; if (cfg_rdy !== 1'b1) begin bad++; $display("FAIL reset_cfg_rdy got=%b exp=1", cfg_rdy); end
    total++; if (req_rdy !== 1'b1) begin bad++; $display("FAIL reset_req_rdy got=%b exp=1", req_rdy); end
    total++; if (resp_word !== 16'h0000) begin bad++; $display("FAIL reset_word got=%h exp=0000", resp_word); end
    total++; if (lfsr_reseed !== 1'b0) begin bad++; $display("FAIL reset_reseed got=%b exp=0", lfsr_reseed); end
  endtask

  task automatic test_basic_word();
    int en_cnt; logic got;
    // samples in order 1,0,1,1,0 -> 5'b10110
    run_word(5'd5, 32'b01101, en_cnt, got);
    total++; if (got !== 1'b1) begin bad++; $display("FAIL basic_resp_val got=%b exp=1", got); end
    total++; if (en_cnt != 5) begin bad++; $display("FAIL basic_en_cycles got=%0d exp=5", en_cnt); end
    total++; if (resp_word !== 16'h0016) begin bad++; $display("FAIL basic_word got=%h exp=0016", resp_word); end
    total++; if (lfsr_en !== EXP_EN_RESP) begin bad++; $display("FAIL basic_en_in_resp got=%b exp=%b", lfsr_en, EXP_EN_RESP); end
    resp_rdy = 1'b1;
    @(negedge clk);
    resp_rdy = 1'b0;
    total++; if (dbg_state !== ST_IDLE || resp_val !== 1'b0) begin bad++; $display("FAIL basic_back_idle state=%0d resp_val=%b exp=0/0", dbg_state, resp_val); end
  endtask

  task automatic test_clamp();
    int en_cnt; logic got;
    logic [NB_W-1:0] nbs [3];
    int exp_cnt [3];
    logic [WORD_W-1:0] exp_w [3];
    nbs = '{5'd0, 5'd20, 5'd1};
    exp_cnt = '{16, 16, 1};
    exp_w = '{16'hFFFF, 16'hFFFF, 16'h0001};
    for (int k = 0; k < 3; k++) begin
      run_word(nbs[k], 32'hFFFF_FFFF, en_cnt, got);
      total++; if (got !== 1'b1 || en_cnt != exp_cnt[k]) begin bad++; $display("FAIL clamp_cycles nb=%0d got=%0d/%b exp=%0d/1", nbs[k], en_cnt, got, exp_cnt[k]); end
      total++; if (resp_word !== exp_w[k]) begin bad++; $display("FAIL clamp_word nb=%0d got=%h exp=%h", nbs[k], resp_word, exp_w[k]); end
      resp_rdy = 1'b1;
      @(negedge clk);
      resp_rdy = 1'b0;
    end
  endtask

  task automatic test_backpressure();
    int en_cnt; logic got;
    // samples 1,1,0 -> 3'b110
    run_word(5'd3, 32'b011, en_cnt, got);
    req_val = 1'b1;
    for (int i = 0; i < 4; i++) begin
      total++;
      if (resp_val !== 1'b1 || resp_word !== 16'h0006 || req_rdy !== 1'b0 || lfsr_en !== EXP_EN_RESP) begin
        bad++;
        $display("FAIL bp_hold cyc=%0d val=%b word=%h req_rdy=%b en=%b exp=1/0006/0/%b", i, resp_val, resp_word, req_rdy, lfsr_en, EXP_EN_RESP);
      end
      @(negedge clk);
    end
    req_val  = 1'b0;
    resp_rdy = 1'b1;
    @(negedge clk);
    resp_rdy = 1'b0;
    total++; if (dbg_state !== ST_IDLE || resp_val !== 1'b0) begin bad++; $display("FAIL bp_release state=%0d val=%b exp=0/0", dbg_state, resp_val); end
  endtask

  task automatic test_reconfig_priority();
    int en_cnt;
    @(negedge clk);
    cfg_val = 1'b1; cfg_tap = 8'h8E; cfg_seed = 8'h5A;
    req_val = 1'b1; req_nbits = 5'd2; lfsr_out = 1'b1;
    #1;
    total++; if (cfg_rdy !== 1'b1 || req_rdy !== 1'b0) begin bad++; $display("FAIL prio_rdy cfg_rdy=%b req_rdy=%b exp=1/0", cfg_rdy, req_rdy); end
    @(negedge clk);
    cfg_val = 1'b0;
    total++; if (lfsr_reseed !== 1'b1 || seed !== 8'h5A || tap !== 8'h8E || dbg_state !== ST_RESEED) begin bad++; $display("FAIL prio_reseed pulse=%b seed=%h tap=%h st=%0d exp=1/5a/8e/1", lfsr_reseed, seed, tap, dbg_state); end
    total++; if (lfsr_en !== 1'b0 || req_rdy !== 1'b0) begin bad++; $display("FAIL prio_reseed_ctl en=%b req_rdy=%b exp=0/0", lfsr_en, req_rdy); end
    @(negedge clk);
    total++; if (lfsr_reseed !== 1'b0 || req_rdy !== 1'b1) begin bad++; $display("FAIL prio_return pulse=%b req_rdy=%b exp=0/1", lfsr_reseed, req_rdy); end
    @(negedge clk);
    req_val = 1'b0;
    en_cnt = 0;
    for (int i = 0; i < 20 && !resp_val; i++) begin
      if (lfsr_en) en_cnt++;
      @(negedge clk);
    end
    total++; if (resp_val !== 1'b1 || en_cnt != 2 || resp_word !== 16'h0003) begin bad++; $display("FAIL prio_req val=%b cyc=%0d word=%h exp=1/2/0003", resp_val, en_cnt, resp_word); end
    resp_rdy = 1'b1;
    @(negedge clk);
    resp_rdy = 1'b0;
  endtask

  task automatic test_midop_reset();
    int seen;
    @(negedge clk);
    req_val = 1'b1; req_nbits = 5'd8; lfsr_out = 1'b1;
    @(negedge clk);
    req_val = 1'b0;
    @(negedge clk);
    @(negedge clk);
    total++; if (dbg_state !== ST_GEN || lfsr_en !== 1'b1) begin bad++; $display("FAIL midop_gen st=%0d en=%b exp=2/1", dbg_state, lfsr_en); end
    rst = 1'b0;
    #1;
    total++; if (dbg_state !== ST_IDLE || lfsr_en !== 1'b0 || resp_word !== 16'h0000) begin bad++; $display("FAIL midop_abort st=%0d en=%b word=%h exp=0/0/0000", dbg_state, lfsr_en, resp_word); end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (resp_val === 1'b1) seen++;
    end
    total++; if (seen != 0 || dbg_state !== ST_IDLE) begin bad++; $display("FAIL midop_no_resp resp_cycles=%0d st=%0d exp=0/0", seen, dbg_state); end
  endtask

  initial begin
    rst = 1'b0; cfg_val = 1'b0; cfg_tap = '0; cfg_seed = '0;
    req_val = 1'b0; req_nbits = '0; resp_rdy = 1'b0; lfsr_out = 1'b0;
    test_reset();
    test_basic_word();
    test_clamp();
    test_backpressure();
    test_reconfig_priority();
    test_midop_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/random_word_ctrl.md
Name: random_word_ctrl

Overview:
- Controller that sequences the 8-bit LFSR random-engine datapath.
- Accepts configuration (tap, seed) and word requests over val/rdy interfaces.
- Enables the LFSR for exactly N cycles and shifts the serial output bits into an N-bit word.
- Returns the word over a val/rdy response interface; drives the datapath's tap, seed and enable controls.

Parameters:
- WORD_W, 16: maximum response word width in bits.
- NB_W, 5: width of req_nbits; must satisfy 2^NB_W > WORD_W.
- RST_TAP, 8'hB8: tap value after reset.
- RST_SEED, 8'h01: seed value after reset.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- cfg_val  in  1  configuration request valid.
- cfg_rdy  out  1  configuration accepted when cfg_val && cfg_rdy.
- cfg_tap  in  8  new tap value.
- cfg_seed  in  8  new seed value.
- req_val  in  1  word request valid.
- req_rdy  out  1  request accepted when req_val && req_rdy.
- req_nbits  in  NB_W  number of random bits requested.
- resp_val  out  1  response word valid.
- resp_rdy  in  1  consumer ready.
- resp_word  out  WORD_W  random word, right-aligned.
- tap  out  8  tap value to the datapath.
- seed  out  8  seed value to the datapath.
- lfsr_reseed  out  1  active-high one-cycle pulse; integration ORs it into the datapath reset so the LFSR reloads seed.
- lfsr_en  out  1  datapath LFSR advance enable.
- lfsr_out  in  1  datapath serial random bit (current LFSR output).

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, tap=RST_TAP, seed=RST_SEED, resp_word=0, bit counter=0, all handshake outputs 0, lfsr_en=0, lfsr_reseed=0.
- Reset mid-operation aborts any GEN or RESP in progress; no response is issued.
- FSM states: IDLE, RESEED, GEN, RESP.
- IDLE:
  - cfg_rdy=1, req_rdy=!cfg_val, so cfg has priority over req when both are valid.
  - On cfg accept: latch cfg_tap/cfg_seed into tap/seed; go to RESEED.
  - On req accept: load counter with the effective count (below); clear resp_word; go to GEN.
- Effective count: req_nbits==0 or req_nbits>WORD_W is treated as WORD_W.
- RESEED: lfsr_reseed=1 for exactly one cycle, with the new seed already on the seed port; then IDLE.
- GEN:
  - lfsr_en=1 every cycle.
  - At each rising edge: resp_word <= {resp_word[WORD_W-2:0], lfsr_out}; counter--.
  - The first sampled bit is the LFSR output before its first advance.
  - When counter==1 at the edge, go to RESP.
  - Exactly N GEN cycles; bits [WORD_W-1:N] of resp_word remain 0.
- RESP:
  - resp_val=1; resp_word held stable while resp_rdy=0.
  - On resp_rdy=1: go to IDLE.
  - lfsr_en=0 and cfg_rdy=req_rdy=0 while in RESP.
- Latency: request accept edge, then N GEN cycles; resp_val is asserted in the cycle after the last GEN edge. Minimum request-to-request interval is N+2 cycles.
- cfg_val and req_val are ignored outside IDLE; no buffering.

Optional Feature:
- Macro: RANDOM_WORD_CTRL_FREERUN_EN.
- Defined: lfsr_en=1 in IDLE and RESP as well as GEN, so the LFSR free-runs and word content depends on idle time. lfsr_en=0 in RESEED. Bit sampling still occurs only in GEN.
- Undefined: lfsr_en=1 only in GEN; the output sequence is fully deterministic per request.

Test Plan:
- Reset defaults: hold rst=0 for 3 cycles, release -> tap=8'hB8, seed=8'h01, resp_val=0, lfsr_en=0, cfg_rdy=1, req_rdy=1.
- Basic word: req_nbits=5; bench drives lfsr_out 1,0,1,1,0 on successive GEN cycles -> lfsr_en high for exactly 5 cycles; resp_val the next cycle; resp_word=16'h0016.
- Clamp and zero: req_nbits=0, then req_nbits=20, lfsr_out=1 throughout -> each request gives 16 enable cycles and resp_word=16'hFFFF.
- Backpressure: resp_rdy=0 for 4 cycles after resp_val -> resp_word stable, req_rdy=0, lfsr_en=0 (macro undefined); IDLE one cycle after resp_rdy=1.
- Reconfig priority: cfg_val=1 and req_val=1 together with cfg_tap=8'h8E, cfg_seed=8'h5A -> cfg accepted, req_rdy=0 that cycle; next cycle lfsr_reseed=1 with seed=8'h5A, tap=8'h8E; req accepted on return to IDLE.
- Mid-op reset: assert rst=0 on the third GEN cycle of an N=8 request -> immediate IDLE, lfsr_en=0, resp_word=0, no resp_val after release.
